// File: rtl/countdown_10000.sv
// Countdown timer: loadable 0..9999 counter that steps down once every TICK_DIV clocks
// while running, pulses o_done when it reaches zero and reports an IDLE/RUN/PAUSE/DONE state.
module countdown_10000 #(
   parameter int unsigned TICK_DIV = 1_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_run_stop,
   input  logic        i_clear,
   input  logic        i_load,
   input  logic [13:0] i_load_val,
   output logic [13:0] o_count,
   output logic        o_done,
   output logic        o_busy,
   output logic [1:0]  o_state
);

   localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [13:0]   COUNT_MAX = 14'd9999;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StPause = 2'd2,
      StDone  = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [13:0]   count_q, count_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          done_q, done_d;
   logic          tick;
   logic [13:0]   load_sat;

   // Out-of-range load values saturate to the display maximum.
   assign load_sat = (i_load_val > COUNT_MAX) ? COUNT_MAX : i_load_val;

   // Next-state, count, prescaler and done-pulse logic; clear overrides everything.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      presc_d = presc_q;
      done_d  = 1'b0;
      tick    = (state_q == StRun) && (presc_q == PRESC_MAX);

      if (i_clear) begin
         state_d = StIdle;
         count_d = '0;
         presc_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               presc_d = '0;
               if (i_load) count_d = load_sat;
               // Start decision uses the count present now, not a value being loaded.
               if (i_run_stop && (count_q != '0)) state_d = StRun;
            end
            StRun: begin
               presc_d = tick ? '0 : presc_q + 1'b1;
               if (!i_run_stop) state_d = StPause;
               if (tick) begin
                  if (count_q > 14'd1) begin
                     count_d = count_q - 14'd1;
                  end else if (count_q == 14'd1) begin
                     count_d = '0;
                     state_d = StDone;
                     done_d  = 1'b1;
                  end
               end
            end
            StPause: begin
               if (i_load) begin
                  count_d = load_sat;
                  presc_d = '0;
               end
               if (i_run_stop) state_d = StRun;
            end
            StDone: begin
               presc_d = '0;
               if (i_load) begin
                  count_d = load_sat;
                  state_d = StIdle;
               end else if (!i_run_stop) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         count_q <= '0;
         presc_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         presc_q <= presc_d;
         done_q  <= done_d;
      end
   end

   assign o_count = count_q;
   assign o_done  = done_q;
   assign o_busy  = (state_q == StRun);
   assign o_state = state_q;

endmodule

// File: tb/tb_countdown_10000.sv
// Bench for countdown_10000 with TICK_DIV=4: directed scenarios plus randomized traffic,
// all compared against a behavioural model of the countdown rules.
module tb_countdown_10000;

   localparam int TD = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_run_stop;
   logic        i_clear;
   logic        i_load;
   logic [13:0] i_load_val;
   logic [13:0] o_count;
   logic        o_done;
   logic        o_busy;
   logic [1:0]  o_state;
   logic [17:0] dut_vec;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: 0=IDLE 1=RUN 2=PAUSE 3=DONE
   int m_count, m_presc, m_state;
   bit m_done;

   countdown_10000 #(.TICK_DIV(TD)) dut (
      .clk        (clk),
      .reset      (reset),
      .i_run_stop (i_run_stop),
      .i_clear    (i_clear),
      .i_load     (i_load),
      .i_load_val (i_load_val),
      .o_count    (o_count),
      .o_done     (o_done),
      .o_busy     (o_busy),
      .o_state    (o_state)
   );

   always #5 clk = ~clk;

   assign dut_vec = {o_count, o_done, o_busy, o_state};

   function automatic void model_reset();
      m_count = 0;
      m_presc = 0;
      m_state = 0;
      m_done  = 0;
   endfunction

   function automatic int sat(input int v);
      return (v > 9999) ? 9999 : v;
   endfunction

   // One clock edge of the countdown rules, applied to the inputs seen at that edge.
   function automatic void model_next();
      int  c  = m_count;
      int  p  = m_presc;
      int  s  = m_state;
      bit  tk = (s == 1) && (p == TD - 1);
      m_done = 0;
      if (i_clear) begin
         m_count = 0;
         m_presc = 0;
         m_state = 0;
         return;
      end
      case (s)
         0: begin
            if (i_load) m_count = sat(int'(i_load_val));
            m_presc = 0;
            m_state = (i_run_stop && c != 0) ? 1 : 0;
         end
         1: begin
            m_presc = tk ? 0 : p + 1;
            if (!i_run_stop) m_state = 2;
            if (tk && c > 1) m_count = c - 1;
            else if (tk && c == 1) begin
               m_count = 0;
               m_state = 3;
               m_done  = 1;
            end
         end
         2: begin
            if (i_load) begin
               m_count = sat(int'(i_load_val));
               m_presc = 0;
            end
            if (i_run_stop) m_state = 1;
         end
         default: begin
            m_presc = 0;
            if (i_load) begin
               m_count = sat(int'(i_load_val));
               m_state = 0;
            end else if (!i_run_stop) m_state = 0;
         end
      endcase
   endfunction

   function automatic logic [17:0] model_vec();
      logic [13:0] c = 14'(m_count);
      logic [1:0]  s = 2'(m_state);
      logic        b = (m_state == 1);
      return {c, m_done, b, s};
   endfunction

   // Advance one clock; leaves time at posedge+1 for sampling and driving.
   task automatic clk_step();
      @(posedge clk);
      if (reset) model_next();
      else model_reset();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; i_run_stop = 1'b1; i_clear = 1'b0; i_load = 1'b0; i_load_val = 14'd0;
      model_reset();
      #1;
      n_total++;
      if (dut_vec !== 18'h0) $display("FAIL reset_async: got %h want %h", dut_vec, 18'h0);
      else n_pass++;
      repeat (2) clk_step();
      n_total++;
      if (dut_vec !== 18'h0) $display("FAIL reset_held: got %h want %h", dut_vec, 18'h0);
      else n_pass++;
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         clk_step();
         n_total++;
         if (dut_vec !== model_vec()) $display("FAIL reset_release: got %h want %h", dut_vec, model_vec());
         else n_pass++;
      end
      i_run_stop = 1'b0;
      clk_step();
   endtask

   task automatic test_basic();
      int dones = 0;
      i_load = 1'b1; i_load_val = 14'd3;
      clk_step();
      i_load = 1'b0;
      n_total++;
      if (o_count !== 14'd3) $display("FAIL basic_load: got %0d want 3", o_count);
      else n_pass++;
      i_run_stop = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         clk_step();
         if (o_done) dones++;
         n_total++;
         if (dut_vec !== model_vec()) $display("FAIL basic_model k=%0d: got %h want %h", k, dut_vec, model_vec());
         else n_pass++;
         if (k == 4 || k == 5 || k == 9 || k == 13) begin
            n_total++;
            if (o_count !== 14'((k == 4) ? 3 : (k == 5) ? 2 : (k == 9) ? 1 : 0))
               $display("FAIL basic_step k=%0d: got %0d", k, o_count);
            else n_pass++;
         end
         if (k == 13 || k == 14 || k == 20) begin
            n_total++;
            if ({o_done, o_state} !== ((k == 13) ? 3'b111 : 3'b011))
               $display("FAIL basic_done k=%0d: got done=%b state=%0d", k, o_done, o_state);
            else n_pass++;
         end
      end
      n_total++;
      if (dones != 1) $display("FAIL basic_done_pulses: got %0d want 1", dones);
      else n_pass++;
      i_run_stop = 1'b0;
      clk_step();
      n_total++;
      if (o_state !== 2'd0) $display("FAIL basic_to_idle: got %0d want 0", o_state);
      else n_pass++;
   endtask

   task automatic test_pause_resume();
      i_load = 1'b1; i_load_val = 14'd5;
      clk_step();
      i_load = 1'b0; i_run_stop = 1'b1;
      repeat (6) clk_step();
      n_total++;
      if (o_count !== 14'd4) $display("FAIL pause_pre: got %0d want 4", o_count);
      else n_pass++;
      i_run_stop = 1'b0;
      for (int k = 0; k < 10; k++) begin
         clk_step();
         n_total++;
         if (dut_vec !== model_vec()) $display("FAIL pause_model k=%0d: got %h want %h", k, dut_vec, model_vec());
         else n_pass++;
      end
      n_total++;
      if ({o_count, o_state} !== {14'd4, 2'd2}) $display("FAIL pause_hold: got %0d/%0d want 4/2", o_count, o_state);
      else n_pass++;
      i_run_stop = 1'b1;
      clk_step();
      clk_step();
      n_total++;
      if ({o_count, o_state} !== {14'd4, 2'd1}) $display("FAIL resume_early: got %0d/%0d want 4/1", o_count, o_state);
      else n_pass++;
      clk_step();
      n_total++;
      if (o_count !== 14'd3) $display("FAIL resume_tick: got %0d want 3", o_count);
      else n_pass++;
      i_clear = 1'b1;
      clk_step();
      i_clear = 1'b0; i_run_stop = 1'b0;
   endtask

   task automatic test_saturation();
      i_load = 1'b1; i_load_val = 14'd12000;
      clk_step();
      i_load = 1'b0;
      n_total++;
      if (o_count !== 14'd9999) $display("FAIL sat_load: got %0d want 9999", o_count);
      else n_pass++;
      i_run_stop = 1'b1;
      repeat (5) clk_step();
      i_load = 1'b1; i_load_val = 14'd7;
      clk_step();
      i_load = 1'b0;
      n_total++;
      if ({o_count, o_state} !== {14'd9998, 2'd1}) $display("FAIL run_load_ignored: got %0d/%0d want 9998/1", o_count, o_state);
      else n_pass++;
      repeat (3) clk_step();
      n_total++;
      if (o_count !== 14'd9997) $display("FAIL run_load_continue: got %0d want 9997", o_count);
      else n_pass++;
      i_clear = 1'b1;
      clk_step();
      i_clear = 1'b0; i_run_stop = 1'b0;
   endtask

   task automatic test_clear_priority();
      i_load = 1'b1; i_load_val = 14'd3;
      clk_step();
      i_load = 1'b0; i_run_stop = 1'b1;
      repeat (5) clk_step();
      n_total++;
      if (o_count !== 14'd2) $display("FAIL clear_pre: got %0d want 2", o_count);
      else n_pass++;
      i_clear = 1'b1; i_load = 1'b1; i_load_val = 14'd50;
      clk_step();
      i_clear = 1'b0; i_load = 1'b0;
      n_total++;
      if (dut_vec !== 18'h0) $display("FAIL clear_prio: got %h want %h", dut_vec, 18'h0);
      else n_pass++;
      for (int k = 0; k < 5; k++) begin
         clk_step();
         n_total++;
         if (dut_vec !== 18'h0) $display("FAIL clear_stay_idle k=%0d: got %h want %h", k, dut_vec, 18'h0);
         else n_pass++;
      end
      i_run_stop = 1'b0;
   endtask

   task automatic test_async_reset();
      i_load = 1'b1; i_load_val = 14'd3;
      clk_step();
      i_load = 1'b0; i_run_stop = 1'b1;
      repeat (3) clk_step();
      n_total++;
      if (o_busy !== 1'b1) $display("FAIL areset_pre: busy got %b want 1", o_busy);
      else n_pass++;
      #3 reset = 1'b0;
      #1;
      n_total++;
      if (dut_vec !== 18'h0) $display("FAIL areset_immediate: got %h want %h", dut_vec, 18'h0);
      else n_pass++;
      model_reset();
      clk_step();
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         clk_step();
         n_total++;
         if (dut_vec !== 18'h0) $display("FAIL areset_after k=%0d: got %h want %h", k, dut_vec, 18'h0);
         else n_pass++;
      end
      i_run_stop = 1'b0;
   endtask

   task automatic test_zero_start();
      i_clear = 1'b1;
      clk_step();
      i_clear = 1'b0; i_run_stop = 1'b1;
      for (int k = 0; k < 4; k++) begin
         clk_step();
         n_total++;
         if ({o_busy, o_state} !== 3'b000) $display("FAIL zero_start k=%0d: got busy=%b state=%0d", k, o_busy, o_state);
         else n_pass++;
      end
      i_run_stop = 1'b0;
      clk_step();
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 9) == 0) i_run_stop = ~i_run_stop;
         i_clear = ($urandom_range(0, 59) == 0);
         i_load  = ($urandom_range(0, 11) == 0);
         case ($urandom_range(0, 3))
            0:       i_load_val = 14'($urandom_range(10000, 16383));
            1:       i_load_val = 14'($urandom_range(0, 9999));
            default: i_load_val = 14'($urandom_range(0, 4));
         endcase
         clk_step();
         n_total++;
         if (dut_vec !== model_vec()) $display("FAIL random k=%0d: got %h want %h", k, dut_vec, model_vec());
         else n_pass++;
      end
      i_clear = 1'b0; i_load = 1'b0; i_run_stop = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_pause_resume();
      test_saturation();
      test_clear_priority();
      test_async_reset();
      test_zero_start();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
